// File: rtl/dmem_arbiter.sv
// Two-master data-memory arbiter: IDLE/ACCESS/RESP serialiser with fixed-priority or round-robin
// selection. Optional statistics counters are built when DMEM_ARB_STATS_EN is defined.
module dmem_arbiter #(
   parameter int unsigned MEM_SIZE_WORDS = 1024,
   parameter int unsigned CPU_PRIO       = 1,
   parameter int unsigned MAX_WAIT       = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        c_req,
   input  logic [31:0] c_addr,
   input  logic [31:0] c_wdata,
   input  logic [3:0]  c_wen,
   output logic        c_ack,
   output logic [31:0] c_rdata,
   input  logic        a_req,
   input  logic [31:0] a_addr,
   input  logic [31:0] a_wdata,
   input  logic [3:0]  a_wen,
   output logic        a_ack,
   output logic [31:0] a_rdata,
   output logic        rsp_err,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   output logic [3:0]  m_wen,
   input  logic [31:0] m_rdata,
   output logic [15:0] stat_cpu_grants,
   output logic [15:0] stat_acc_grants,
   output logic [15:0] stat_conflicts
);

   localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);
   localparam logic [WaitW-1:0] MaxWait = WaitW'(MAX_WAIT);
   localparam logic [32:0] MemBytes = 33'(MEM_SIZE_WORDS) * 33'd4;

   typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

   state_e           state_q;
   logic [31:0]      addr_q;
   logic [31:0]      wdata_q;
   logic [3:0]       wen_q;
   logic             owner_acc_q;
   logic             last_acc_q;
   logic [WaitW-1:0] wait_cnt_q;
   logic [31:0]      rsp_q;
   logic             rsp_err_q;
   logic             c_ack_q;
   logic             a_ack_q;

   logic any_req;
   logic acc_pref;
   logic acc_wins;
   logic in_range;

   always_comb begin
      any_req  = c_req | a_req;
      // On a tie: fixed priority yields only to a starved accelerator, round-robin to whoever
      // was not served last.
      acc_pref = (CPU_PRIO != 0) ? (wait_cnt_q == MaxWait) : !last_acc_q;
      acc_wins = a_req & (!c_req | acc_pref);
      in_range = {1'b0, addr_q} < MemBytes;
   end

   assign m_addr  = addr_q;
   assign m_wdata = wdata_q;
   assign m_wen   = (state_q == StAccess && in_range && !rst) ? wen_q : 4'b0000;
   assign c_ack   = c_ack_q;
   assign a_ack   = a_ack_q;
   assign c_rdata = rsp_q;
   assign a_rdata = rsp_q;
   assign rsp_err = rsp_err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         addr_q      <= '0;
         wdata_q     <= '0;
         wen_q       <= '0;
         owner_acc_q <= 1'b0;
         last_acc_q  <= 1'b1;
         wait_cnt_q  <= '0;
         rsp_q       <= '0;
         rsp_err_q   <= 1'b0;
         c_ack_q     <= 1'b0;
         a_ack_q     <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (any_req) begin
                  owner_acc_q <= acc_wins;
                  last_acc_q  <= acc_wins;
                  addr_q      <= acc_wins ? a_addr  : c_addr;
                  wdata_q     <= acc_wins ? a_wdata : c_wdata;
                  wen_q       <= acc_wins ? a_wen   : c_wen;
                  state_q     <= StAccess;
                  if (acc_wins) begin
                     wait_cnt_q <= '0;
                  end else if (a_req && wait_cnt_q != MaxWait) begin
                     wait_cnt_q <= wait_cnt_q + 1'b1;
                  end
               end
            end
            StAccess: begin
               rsp_q     <= in_range ? m_rdata : 32'h0;
               rsp_err_q <= !in_range;
               c_ack_q   <= !owner_acc_q;
               a_ack_q   <= owner_acc_q;
               state_q   <= StResp;
            end
            StResp: begin
               c_ack_q   <= 1'b0;
               a_ack_q   <= 1'b0;
               rsp_err_q <= 1'b0;
               state_q   <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

`ifdef DMEM_ARB_STATS_EN
   logic [15:0] stat_cpu_q;
   logic [15:0] stat_acc_q;
   logic [15:0] stat_conf_q;
   logic        decide;

   assign decide = (state_q == StIdle) && any_req;

   always_ff @(posedge clk) begin
      if (rst) begin
         stat_cpu_q  <= '0;
         stat_acc_q  <= '0;
         stat_conf_q <= '0;
      end else if (decide) begin
         if (acc_wins) begin
            stat_acc_q <= (stat_acc_q == 16'hFFFF) ? stat_acc_q : stat_acc_q + 16'd1;
         end else begin
            stat_cpu_q <= (stat_cpu_q == 16'hFFFF) ? stat_cpu_q : stat_cpu_q + 16'd1;
         end
         if (c_req && a_req) begin
            stat_conf_q <= (stat_conf_q == 16'hFFFF) ? stat_conf_q : stat_conf_q + 16'd1;
         end
      end
   end

   assign stat_cpu_grants = stat_cpu_q;
   assign stat_acc_grants = stat_acc_q;
   assign stat_conflicts  = stat_conf_q;
`else
   assign stat_cpu_grants = 16'h0;
   assign stat_acc_grants = 16'h0;
   assign stat_conflicts  = 16'h0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a round-robin instance and a fixed-priority instance
// (MAX_WAIT=3), each with its own memory, checked against a queue of expected acks.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        c_req   [2];
   logic [31:0] c_addr  [2];
   logic [31:0] c_wdata [2];
   logic [3:0]  c_wen   [2];
   logic        c_ack   [2];
   logic [31:0] c_rdata [2];
   logic        a_req   [2];
   logic [31:0] a_addr  [2];
   logic [31:0] a_wdata [2];
   logic [3:0]  a_wen   [2];
   logic        a_ack   [2];
   logic [31:0] a_rdata [2];
   logic        rsp_err [2];
   logic [31:0] m_addr  [2];
   logic [31:0] m_wdata [2];
   logic [3:0]  m_wen   [2];
   logic [31:0] m_rdata [2];
   logic [15:0] st_cpu  [2];
   logic [15:0] st_acc  [2];
   logic [15:0] st_conf [2];

   logic [31:0] mem0   [1024];
   logic [31:0] mem1   [1024];
   logic [31:0] shadow [2][1024];

   int cyc = 0;
   int checks = 0;
   int passes = 0;
   int fails = 0;

   typedef struct {
      bit          acc;
      logic [31:0] rdata;
      bit          err;
      int          cyc;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dmem_arbiter #(.MEM_SIZE_WORDS(1024), .CPU_PRIO(0), .MAX_WAIT(8)) dut0 (
      .clk(clk), .rst(rst),
      .c_req(c_req[0]), .c_addr(c_addr[0]), .c_wdata(c_wdata[0]), .c_wen(c_wen[0]),
      .c_ack(c_ack[0]), .c_rdata(c_rdata[0]),
      .a_req(a_req[0]), .a_addr(a_addr[0]), .a_wdata(a_wdata[0]), .a_wen(a_wen[0]),
      .a_ack(a_ack[0]), .a_rdata(a_rdata[0]),
      .rsp_err(rsp_err[0]), .m_addr(m_addr[0]), .m_wdata(m_wdata[0]), .m_wen(m_wen[0]),
      .m_rdata(m_rdata[0]), .stat_cpu_grants(st_cpu[0]), .stat_acc_grants(st_acc[0]),
      .stat_conflicts(st_conf[0])
   );

   dmem_arbiter #(.MEM_SIZE_WORDS(1024), .CPU_PRIO(1), .MAX_WAIT(3)) dut1 (
      .clk(clk), .rst(rst),
      .c_req(c_req[1]), .c_addr(c_addr[1]), .c_wdata(c_wdata[1]), .c_wen(c_wen[1]),
      .c_ack(c_ack[1]), .c_rdata(c_rdata[1]),
      .a_req(a_req[1]), .a_addr(a_addr[1]), .a_wdata(a_wdata[1]), .a_wen(a_wen[1]),
      .a_ack(a_ack[1]), .a_rdata(a_rdata[1]),
      .rsp_err(rsp_err[1]), .m_addr(m_addr[1]), .m_wdata(m_wdata[1]), .m_wen(m_wen[1]),
      .m_rdata(m_rdata[1]), .stat_cpu_grants(st_cpu[1]), .stat_acc_grants(st_acc[1]),
      .stat_conflicts(st_conf[1])
   );

   // Memories: combinational read, byte-enabled write on the clock edge.
   assign m_rdata[0] = mem0[m_addr[0][11:2]];
   assign m_rdata[1] = mem1[m_addr[1][11:2]];

   always @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (m_wen[0][b]) mem0[m_addr[0][11:2]][8*b +: 8] <= m_wdata[0][8*b +: 8];
         if (m_wen[1][b]) mem1[m_addr[1][11:2]][8*b +: 8] <= m_wdata[1][8*b +: 8];
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic drive(input int i, input bit acc, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wen);
      if (acc) begin
         a_req[i] = 1'b1; a_addr[i] = addr; a_wdata[i] = wdata; a_wen[i] = wen;
      end else begin
         c_req[i] = 1'b1; c_addr[i] = addr; c_wdata[i] = wdata; c_wen[i] = wen;
      end
   endtask

   // Expected response for an access served in this order: old word for in-range, 0 + err else.
   task automatic push(input int i, input bit acc, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wen, input int at);
      exp_t e;
      e.acc = acc;
      e.cyc = at;
      if (addr < 32'h1000) begin
         e.rdata = shadow[i][addr[11:2]];
         e.err   = 1'b0;
         for (int b = 0; b < 4; b++) begin
            if (wen[b]) shadow[i][addr[11:2]][8*b +: 8] = wdata[8*b +: 8];
         end
      end else begin
         e.rdata = 32'h0;
         e.err   = 1'b1;
      end
      sb.push_back(e);
   endtask

   // Consume expected acks; the CPU re-requests the cycle after its ack while rereq > 0.
   task automatic run(input int i, input int budget, input int rereq);
      int   left;
      int   rq;
      bit   pend;
      exp_t e;
      left = budget;
      rq   = rereq;
      pend = 1'b0;
      while (sb.size() > 0 && left > 0) begin
         @(negedge clk);
         left--;
         if (pend) begin
            c_req[i] = 1'b1;
            pend     = 1'b0;
         end
         if (c_ack[i] || a_ack[i]) begin
            e = sb.pop_front();
            chk("ack_owner", 32'(a_ack[i]), 32'(e.acc));
            chk("other_ack", 32'(e.acc ? c_ack[i] : a_ack[i]), 32'h0);
            chk("rdata", e.acc ? a_rdata[i] : c_rdata[i], e.rdata);
            chk("rsp_err", 32'(rsp_err[i]), 32'(e.err));
            chk("ack_cycle", cyc, e.cyc);
            if (c_ack[i]) begin
               c_req[i] = 1'b0;
               if (rq > 0) begin
                  rq--;
                  pend = 1'b1;
               end
            end
            if (a_ack[i]) a_req[i] = 1'b0;
         end
      end
      if (sb.size() > 0) begin
         chk("ack_timeout", sb.size(), 32'h0);
         sb.delete();
      end
   endtask

   task automatic reset_pulse();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int t;
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         c_req[i] = 0; c_addr[i] = 0; c_wdata[i] = 0; c_wen[i] = 0;
         a_req[i] = 0; a_addr[i] = 0; a_wdata[i] = 0; a_wen[i] = 0;
      end
      for (int w = 0; w < 1024; w++) begin
         mem0[w] = 32'h0; mem1[w] = 32'h0; shadow[0][w] = 32'h0; shadow[1][w] = 32'h0;
      end
      repeat (2) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk("rst_c_ack", 32'(c_ack[i]), 32'h0);
         chk("rst_a_ack", 32'(a_ack[i]), 32'h0);
         chk("rst_err", 32'(rsp_err[i]), 32'h0);
         chk("rst_m_wen", 32'(m_wen[i]), 32'h0);
         chk("rst_m_addr", m_addr[i], 32'h0);
         chk("rst_m_wdata", m_wdata[i], 32'h0);
         chk("rst_rdata", c_rdata[i], 32'h0);
         chk("rst_stats", {st_cpu[i], st_acc[i] | st_conf[i]}, 32'h0);
      end
      rst = 1'b0;

      // Single CPU write then read-back.
      @(negedge clk);
      t = cyc;
      drive(0, 0, 32'h300, 32'hDEADBEEF, 4'b1111);
      push(0, 0, 32'h300, 32'hDEADBEEF, 4'b1111, t + 2);
      @(negedge clk);
      chk("wr_m_wen_access", 32'(m_wen[0]), 32'hF);
      chk("wr_m_addr", m_addr[0], 32'h300);
      chk("wr_m_wdata", m_wdata[0], 32'hDEADBEEF);
      run(0, 10, 0);
      chk("wr_m_wen_resp", 32'(m_wen[0]), 32'h0);
      chk("wr_mem", mem0[32'h300 >> 2], 32'hDEADBEEF);
      @(negedge clk);
      t = cyc;
      drive(0, 0, 32'h300, 32'h0, 4'b0000);
      push(0, 0, 32'h300, 32'h0, 4'b0000, t + 2);
      run(0, 10, 0);

      // Round-robin tie from reset: CPU first; CPU's immediate re-request then loses.
      reset_pulse();
      @(negedge clk);
      t = cyc;
      drive(0, 0, 32'h300, 32'h0, 4'b0000);
      drive(0, 1, 32'h10, 32'hA5A5A5A5, 4'b1111);
      push(0, 0, 32'h300, 32'h0, 4'b0000, t + 2);
      push(0, 1, 32'h10, 32'hA5A5A5A5, 4'b1111, t + 5);
      push(0, 0, 32'h300, 32'h0, 4'b0000, t + 8);
      run(0, 20, 1);
      // CPU was served last, so a fresh tie goes to the accelerator.
      @(negedge clk);
      t = cyc;
      drive(0, 0, 32'h10, 32'h0, 4'b0000);
      drive(0, 1, 32'h300, 32'h0, 4'b0000);
      push(0, 1, 32'h300, 32'h0, 4'b0000, t + 2);
      push(0, 0, 32'h10, 32'h0, 4'b0000, t + 5);
      run(0, 20, 0);

      // Out-of-range accelerator write: no memory write, error response.
      @(negedge clk);
      t = cyc;
      drive(0, 1, 32'h1000, 32'h12345678, 4'b1111);
      push(0, 1, 32'h1000, 32'h12345678, 4'b1111, t + 2);
      @(negedge clk);
      chk("oor_m_wen", 32'(m_wen[0]), 32'h0);
      run(0, 10, 0);
      chk("oor_mem0", mem0[0], 32'h0);

      // Reset while a write to 0x304 is in ACCESS.
      @(negedge clk);
      drive(0, 0, 32'h304, 32'hCAFEF00D, 4'b1111);
      @(negedge clk);
      rst = 1'b1;
      c_req[0] = 1'b0;
      #1;
      chk("rst_gate_m_wen", 32'(m_wen[0]), 32'h0);
      @(negedge clk);
      chk("rstacc_c_ack", 32'(c_ack[0]), 32'h0);
      chk("rstacc_m_wen", 32'(m_wen[0]), 32'h0);
      chk("rstacc_m_addr", m_addr[0], 32'h0);
      chk("rstacc_m_wdata", m_wdata[0], 32'h0);
      chk("rstacc_mem", mem0[32'h304 >> 2], 32'h0);
      rst = 1'b0;
      @(negedge clk);
      t = cyc;
      drive(0, 0, 32'h304, 32'h0, 4'b0000);
      push(0, 0, 32'h304, 32'h0, 4'b0000, t + 2);
      run(0, 10, 0);

      // Statistics: 2 ties (each serves both), then 4 CPU-only and 3 accelerator-only.
      reset_pulse();
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         t = cyc;
         drive(0, 0, 32'h40 + 32'(4 * k), 32'h100 + 32'(k), 4'b1111);
         drive(0, 1, 32'h80, 32'h0, 4'b0000);
         push(0, 0, 32'h40 + 32'(4 * k), 32'h100 + 32'(k), 4'b1111, t + 2);
         push(0, 1, 32'h80, 32'h0, 4'b0000, t + 5);
         run(0, 20, 0);
      end
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         t = cyc;
         drive(0, k >= 4, 32'h40, 32'h0, 4'b0000);
         push(0, k >= 4, 32'h40, 32'h0, 4'b0000, t + 2);
         run(0, 10, 0);
      end
`ifdef DMEM_ARB_STATS_EN
      chk("stat_cpu", 32'(st_cpu[0]), 32'd6);
      chk("stat_acc", 32'(st_acc[0]), 32'd5);
      chk("stat_conf", 32'(st_conf[0]), 32'd2);
`else
      chk("stat_cpu", 32'(st_cpu[0]), 32'd0);
      chk("stat_acc", 32'(st_acc[0]), 32'd0);
      chk("stat_conf", 32'(st_conf[0]), 32'd0);
`endif

      // Starvation guard, fixed priority, MAX_WAIT=3.
      @(negedge clk);
      t = cyc;
      drive(1, 0, 32'h0, 32'h0, 4'b0000);
      drive(1, 1, 32'h8, 32'h11112222, 4'b1111);
      push(1, 0, 32'h0, 32'h0, 4'b0000, t + 2);
      push(1, 0, 32'h0, 32'h0, 4'b0000, t + 5);
      push(1, 0, 32'h0, 32'h0, 4'b0000, t + 8);
      push(1, 1, 32'h8, 32'h11112222, 4'b1111, t + 11);
      push(1, 0, 32'h0, 32'h0, 4'b0000, t + 14);
      run(1, 40, 3);
      chk("starve_wait_cnt", 32'(dut1.wait_cnt_q), 32'h0);
      chk("starve_mem", mem1[2], 32'h11112222);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
